cwc_capture_reader: RTL and testbench

// - Readback end of the ChipWatcher capture path: after a capture completes, reads stored samples from the trigger RAM

---
 rtl/cwc_rd_pkg.sv | 20 ++
 rtl/cwc_chunk_serializer.sv | 58 +++++
 rtl/cwc_capture_reader.sv | 162 ++++++++++++++++
 tb/tb_cwc_capture_reader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cwc_rd_pkg.sv
// Shared types and helpers for the ChipWatcher capture readback path.
package cwc_rd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        RD   = 3'd2,
        WAIT = 3'd3,
        SEND = 3'd4,
        DONE = 3'd5
    } rd_state_e;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // Number of w-bit beats needed to carry a len-bit sample.
    function automatic int chunks(input int len, input int w);
        return (len + w - 1) / w;
    endfunction

endpackage

// File: rtl/cwc_chunk_serializer.sv
// Holds one RAM sample and presents it as zero-padded WORD_W chunks, LSB chunk first.
module cwc_chunk_serializer
    import cwc_rd_pkg::*;
#(
    parameter int RAM_LEN = 425,
    parameter int WORD_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [RAM_LEN-1:0] sample_i,
    input  logic               advance_i,
    input  logic               clear_i,
    output logic [WORD_W-1:0]  word_o,
    output logic               last_chunk_o
);

    localparam int CHUNKS = chunks(RAM_LEN, WORD_W);
    localparam int PAD_W  = CHUNKS * WORD_W;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    logic [PAD_W-1:0] sample_q, sample_d;
    logic [IDX_W-1:0] chunk_q, chunk_d;
    logic             last_s;

    assign last_s = (chunk_q == IDX_W'(CHUNKS - 1));

    // Next-state for the sample register and chunk index; a clear (abort) beats a load.
    always_comb begin
        sample_d = sample_q;
        chunk_d  = chunk_q;
        if (clear_i) begin
            chunk_d = '0;
        end else if (load_i) begin
            sample_d = PAD_W'(sample_i);
            chunk_d  = '0;
        end else if (advance_i) begin
            chunk_d = last_s ? '0 : (chunk_q + IDX_W'(1));
        end else begin
            chunk_d = chunk_q;
        end
    end

    // Sample and chunk registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            chunk_q  <= '0;
        end else begin
            sample_q <= sample_d;
            chunk_q  <= chunk_d;
        end
    end

    assign word_o       = sample_q[int'(chunk_q) * WORD_W +: WORD_W];
    assign last_chunk_o = last_s;

endmodule

// File: rtl/cwc_capture_reader.sv
// Capture RAM readback: streams stored samples oldest-first as WORD_W beats.
// Optional feature macro CWC_RD_HEADER_EN: prepends one header beat
// {A5, CHUNKS, sample count} to every transfer.
module cwc_capture_reader
    import cwc_rd_pkg::*;
#(
    parameter  int RAM_LEN        = 425,
    parameter  int RAM_DATA_DEPTH = 4096,
    parameter  int WORD_W         = 32,
    localparam int ADDR_W         = $clog2(RAM_DATA_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [ADDR_W:0]    num_samples,
    input  logic               abort,
    output logic               ram_rd_en,
    output logic [ADDR_W-1:0]  ram_rd_addr,
    input  logic [RAM_LEN-1:0] ram_rd_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WORD_W-1:0]  m_data,
    output logic               m_last,
    output logic               busy,
    output logic               done
);

    localparam int CHUNKS = chunks(RAM_LEN, WORD_W);

    rd_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     left_q, left_d;
    logic [ADDR_W:0]     num_clamped_s;
    logic                load_s, adv_s, clr_s;
    logic [WORD_W-1:0]   word_s;
    logic                last_chunk_s;
    logic [WORD_W-1:0]   header_s;

    assign num_clamped_s = (num_samples > (ADDR_W + 1)'(RAM_DATA_DEPTH))
                         ? (ADDR_W + 1)'(RAM_DATA_DEPTH) : num_samples;

    // left_q still holds the full clamped count while the header is on the bus.
    assign header_s = WORD_W'({HDR_MAGIC, 8'(CHUNKS), 16'(left_q)});

    cwc_chunk_serializer #(
        .RAM_LEN (RAM_LEN),
        .WORD_W  (WORD_W)
    ) u_ser (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_s),
        .sample_i     (ram_rd_data),
        .advance_i    (adv_s),
        .clear_i      (clr_s),
        .word_o       (word_s),
        .last_chunk_o (last_chunk_s)
    );

    // Next-state logic; abort from any active state overrides every other transition.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        load_s  = 1'b0;
        adv_s   = 1'b0;
        clr_s   = 1'b0;
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            clr_s   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_d = start_addr;
                        left_d = num_clamped_s;
`ifdef CWC_RD_HEADER_EN
                        state_d = HDR;
`else
                        state_d = (num_clamped_s != '0) ? RD : DONE;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                HDR: begin
                    if (m_ready) begin
                        state_d = (left_q != '0) ? RD : DONE;
                    end else begin
                        state_d = HDR;
                    end
                end
                RD: begin
                    // Address and remaining count advance as the read is issued.
                    addr_d  = addr_q + ADDR_W'(1);
                    left_d  = left_q - (ADDR_W + 1)'(1);
                    state_d = WAIT;
                end
                WAIT: begin
                    load_s  = 1'b1;
                    state_d = SEND;
                end
                SEND: begin
                    if (m_ready) begin
                        adv_s = 1'b1;
                        if (last_chunk_s) begin
                            state_d = (left_q != '0) ? RD : DONE;
                        end else begin
                            state_d = SEND;
                        end
                    end else begin
                        state_d = SEND;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, address and sample-count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
        end
    end

    // Moore output decode: everything derives from registered state only.
    always_comb begin
        ram_rd_en   = (state_q == RD);
        ram_rd_addr = addr_q;
        m_valid     = (state_q == SEND) || (state_q == HDR);
        busy        = (state_q == HDR) || (state_q == RD) ||
                      (state_q == WAIT) || (state_q == SEND);
        done        = (state_q == DONE);
        case (state_q)
            SEND: begin
                m_data = word_s;
                m_last = last_chunk_s && (left_q == '0);
            end
            HDR: begin
                m_data = header_s;
                m_last = (left_q == '0);
            end
            default: begin
                m_data = '0;
                m_last = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cwc_capture_reader.sv
// Self-checking bench for cwc_capture_reader with a queue-based reference model.
module tb_cwc_capture_reader;

    localparam int RAM_LEN = 425;
    localparam int DEPTH   = 4096;
    localparam int WORD_W  = 32;
    localparam int ADDR_W  = 12;
    localparam int CHUNKS  = (RAM_LEN + WORD_W - 1) / WORD_W;
`ifdef CWC_RD_HEADER_EN
    localparam int HOFF = 1;
`else
    localparam int HOFF = 0;
`endif

    logic               clk;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  start_addr;
    logic [ADDR_W:0]    num_samples;
    logic               abort;
    logic               ram_rd_en;
    logic [ADDR_W-1:0]  ram_rd_addr;
    logic [RAM_LEN-1:0] ram_rd_data;
    logic               m_valid;
    logic               m_ready;
    logic [WORD_W-1:0]  m_data;
    logic               m_last;
    logic               busy;
    logic               done;

    cwc_capture_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .num_samples (num_samples),
        .abort       (abort),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture RAM model: one-cycle read latency.
    logic [RAM_LEN-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Observed traffic
    logic [31:0] got_d[$];
    bit          got_l[$];
    int          addr_log[$];
    int          cyc = 0;
    int          start_cyc, done_cyc, last_hs_cyc, done_cnt, stall_viol;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    int          ready_mode = 0;

    // Expected traffic
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    int          exp_a[$];

    // Monitor: samples everything on the falling edge.
    always @(negedge clk) begin
        if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_viol++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (ram_rd_en) addr_log.push_back(int'(ram_rd_addr));
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            last_hs_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (start && !busy) start_cyc = cyc;
        cyc++;
    end

    // Ready driver: always-ready or 50% random.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom % 2);
        end
    end

    task automatic clear_logs();
        got_d.delete();
        got_l.delete();
        addr_log.delete();
        done_cnt    = 0;
        stall_viol  = 0;
        prev_stall  = 1'b0;
        start_cyc   = -100;
        done_cyc    = -1;
        last_hs_cyc = -10;
    endtask

    // Reference: what the hub should see for a given start address and count.
    task automatic build_expected(input int sa, input int ns);
        int n;
        logic [CHUNKS*WORD_W-1:0] pad;
        n = (ns > DEPTH) ? DEPTH : ns;
        exp_d.delete();
        exp_l.delete();
        exp_a.delete();
        if (HOFF == 1) begin
            exp_d.push_back({8'hA5, 8'(CHUNKS), 16'(n)});
            exp_l.push_back(n == 0);
        end
        for (int i = 0; i < n; i++) begin
            int a;
            a = (sa + i) % DEPTH;
            exp_a.push_back(a);
            pad = '0;
            pad[RAM_LEN-1:0] = mem[a];
            for (int k = 0; k < CHUNKS; k++) begin
                exp_d.push_back(pad[k*WORD_W +: WORD_W]);
                exp_l.push_back((i == n - 1) && (k == CHUNKS - 1));
            end
        end
    endtask

    task automatic pulse_start(input int sa, input int ns);
        @(posedge clk);
        #1;
        start       = 1'b1;
        start_addr  = ADDR_W'(sa);
        num_samples = (ADDR_W + 1)'(ns);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_xfer(input string tag, input int sa, input int ns, input int rmode, input bit inject);
        int bound;
        build_expected(sa, ns);
        clear_logs();
        ready_mode = rmode;
        pulse_start(sa, ns);
        bound = exp_d.size() * 4 + 60;
        for (int i = 0; i < bound && done_cnt == 0; i++) begin
            if (inject && i == 100) begin
                check_eq({tag, "_busy_mid"}, 32'(busy), 32'd1);
                start       = 1'b1;
                start_addr  = ADDR_W'(7);
                num_samples = (ADDR_W + 1)'(3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_beats"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            check_eq($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
        end
        check_eq({tag, "_reads"}, addr_log.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < addr_log.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), addr_log[i], exp_a[i]);
        end
        if (exp_d.size() > 0) check_eq({tag, "_done_lat"}, done_cyc, last_hs_cyc + 1);
        else                  check_eq({tag, "_done_lat"}, done_cyc, start_cyc + 1);
        check_eq({tag, "_stall_hold"}, stall_viol, 0);
        ready_mode = 0;
    endtask

    initial begin
        logic [CHUNKS*WORD_W-1:0] tmp;
        logic [31:0] beat;
        bit found;

        for (int a = 0; a < DEPTH; a++) begin
            for (int k = 0; k < CHUNKS; k++) tmp[k*WORD_W +: WORD_W] = $urandom;
            mem[a] = tmp[RAM_LEN-1:0];
        end

        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        start_addr  = '0;
        num_samples = '0;
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", 32'(m_valid), 32'd0);
        check_eq("rst_busy",  32'(busy),    32'd0);
        check_eq("rst_done",  32'(done),    32'd0);
        check_eq("rst_rden",  32'(ram_rd_en), 32'd0);
        check_eq("rst_last",  32'(m_last),  32'd0);
        check_eq("rst_data",  m_data,       32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two samples, always ready; last chunk must be zero-padded above bit 424.
        run_xfer("basic", 0, 2, 0, 1'b0);
        if (got_d.size() > 13 + HOFF) begin
            beat = got_d[13 + HOFF];
            check_eq("pad_zero", 32'(beat[31:9]), 32'd0);
        end else begin
            check_eq("pad_present", got_d.size(), 14 + HOFF);
        end

        // Address wrap at the top of the RAM.
        run_xfer("wrap", 4094, 4, 0, 1'b0);

        // Back-pressure: same stream as the always-ready run, held while stalled.
        run_xfer("stall_basic", 0, 2, 1, 1'b0);
        for (int it = 0; it < 3; it++) begin
            run_xfer($sformatf("rnd%0d", it), int'($urandom_range(0, DEPTH - 1)),
                     int'($urandom_range(1, 6)), 1, 1'b0);
        end
        run_xfer("three", 100, 3, 1, 1'b0);

        // Abort while presenting chunk 5 of the third sample.
        clear_logs();
        ready_mode = 1;
        pulse_start(200, 5);
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (m_valid && got_d.size() == 2 * CHUNKS + 5 + HOFF) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check_eq("abort_reach", 32'(found), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check_eq("abort_valid", 32'(m_valid), 32'd0);
        check_eq("abort_busy",  32'(busy),    32'd0);
        check_eq("abort_rden",  32'(ram_rd_en), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("abort_nodone", done_cnt, 0);
        ready_mode = 0;
        run_xfer("post_abort", 1234, 3, 1, 1'b0);

        // Zero-length, then oversized count with a start attempted while busy.
        run_xfer("zero", 5, 0, 0, 1'b0);
        run_xfer("clamp", 4000, 5000, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
